// File: rtl/multicycle_controller.sv
// Multi-cycle control unit for the Tessia ARM-subset datapath: FSM sequencing, ALU decode,
// NZCV flag register and ARM condition evaluation.
module multicycle_controller #(
  parameter int unsigned ALUCTL_W    = 4,
  parameter int unsigned MUL_LATENCY = 3,
  parameter logic [3:0]  PC_REG      = 4'd15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          Op,
  input  logic [5:0]          Funct,
  input  logic [3:0]          Rd,
  input  logic [3:0]          Cond,
  input  logic [3:0]          ALUFlags,
  output logic                PCWrite,
  output logic                AdrSrc,
  output logic                MemW,
  output logic                IRWrite,
  output logic                RegW,
  output logic [1:0]          ResultSrc,
  output logic [1:0]          ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [1:0]          ImmSrc,
  output logic [1:0]          RegSrc,
  output logic [ALUCTL_W-1:0] ALUControl,
  output logic [3:0]          Flags,
  output logic                Illegal
);

  localparam int unsigned CntW = (MUL_LATENCY > 2) ? $clog2(MUL_LATENCY) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(MUL_LATENCY - 2);

  typedef enum logic [3:0] {
    StFetch, StDecode, StMemAdr, StMemRd, StMemWb, StMemWr,
    StExecR, StExecI, StMulWait, StAluWb, StBranch
  } state_e;

  state_e          state_q;
  logic [3:0]      flags_q;
  logic [CntW-1:0] cnt_q;
  logic [3:0]      alu_q;
  logic            mul_q, cmp_q, cv_q, setf_q, cond_q;

  logic [3:0] dec_ctl;
  logic       dec_ok, dec_mul, dec_cmp, dec_cv;
  logic       condex, illegal_dec;
  logic [3:0] flags_upd;

  always_comb begin
    dec_ctl = 4'b0000;
    dec_ok  = 1'b1;
    dec_mul = 1'b0;
    dec_cmp = 1'b0;
    dec_cv  = 1'b0;
    case (Funct[4:1])
      4'b0100: begin dec_ctl = 4'b0000; dec_cv = 1'b1; end
      4'b0010: begin dec_ctl = 4'b0001; dec_cv = 1'b1; end
      4'b0000: begin dec_ctl = 4'b0010; dec_mul = 1'b1; end
      4'b1100: dec_ctl = 4'b0011;
      4'b1101: dec_ctl = 4'b0110;
      4'b1010: begin dec_ctl = 4'b0001; dec_cv = 1'b1; dec_cmp = 1'b1; end
      default: dec_ok = 1'b0;
    endcase
  end

  // Condition evaluated against the registered flags, {N,Z,C,V}.
  always_comb begin
    condex = 1'b1;
    case (Cond)
      4'b0000: condex = flags_q[2];
      4'b0001: condex = ~flags_q[2];
      4'b0010: condex = flags_q[1];
      4'b0011: condex = ~flags_q[1];
      4'b0100: condex = flags_q[3];
      4'b0101: condex = ~flags_q[3];
      4'b0110: condex = flags_q[0];
      4'b0111: condex = ~flags_q[0];
      4'b1000: condex = flags_q[1] & ~flags_q[2];
      4'b1001: condex = ~flags_q[1] | flags_q[2];
      4'b1010: condex = (flags_q[3] == flags_q[0]);
      4'b1011: condex = (flags_q[3] != flags_q[0]);
      4'b1100: condex = ~flags_q[2] & (flags_q[3] == flags_q[0]);
      4'b1101: condex = flags_q[2] | (flags_q[3] != flags_q[0]);
      default: condex = 1'b1;
    endcase
  end

  assign illegal_dec = (Op == 2'b11) || ((Op == 2'b00) && !dec_ok);
  assign flags_upd   = {ALUFlags[3:2], cv_q ? ALUFlags[1:0] : flags_q[1:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StFetch;
      flags_q <= 4'b0000;
      cnt_q   <= '0;
      alu_q   <= 4'b0000;
      mul_q   <= 1'b0;
      cmp_q   <= 1'b0;
      cv_q    <= 1'b0;
      setf_q  <= 1'b0;
      cond_q  <= 1'b0;
    end else begin
      case (state_q)
        StFetch: state_q <= StDecode;
        StDecode: begin
          alu_q  <= dec_ctl;
          mul_q  <= dec_mul;
          cmp_q  <= dec_cmp;
          cv_q   <= dec_cv;
          setf_q <= Funct[0];
          cond_q <= condex;
          if (!condex || illegal_dec) begin
            state_q <= StFetch;
          end else begin
            case (Op)
              2'b00:   state_q <= Funct[5] ? StExecI : StExecR;
              2'b01:   state_q <= StMemAdr;
              2'b10:   state_q <= StBranch;
              default: state_q <= StFetch;
            endcase
          end
        end
        StExecR, StExecI: begin
          if (mul_q && (MUL_LATENCY > 1)) begin
            state_q <= StMulWait;
            cnt_q   <= '0;
          end else begin
            if (setf_q && cond_q) flags_q <= flags_upd;
            state_q <= cmp_q ? StFetch : StAluWb;
          end
        end
        StMulWait: begin
          if (cnt_q == CntLast) begin
            if (setf_q && cond_q) flags_q <= flags_upd;
            state_q <= StAluWb;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StMemAdr: state_q <= Funct[0] ? StMemRd : StMemWr;
        StMemRd:  state_q <= StMemWb;
        default:  state_q <= StFetch;
      endcase
    end
  end

  logic       pcw, irw, regw, memw, ill, adr;
  logic [1:0] rs, sa, sb;
  logic [3:0] alu_sel;

  always_comb begin
    pcw     = 1'b0;
    irw     = 1'b0;
    regw    = 1'b0;
    memw    = 1'b0;
    ill     = 1'b0;
    adr     = 1'b0;
    rs      = 2'b00;
    sa      = 2'b00;
    sb      = 2'b00;
    alu_sel = 4'b0000;
    ImmSrc  = 2'b00;
    RegSrc  = 2'b00;
    if (state_q != StFetch) begin
      case (Op)
        2'b01:   begin ImmSrc = 2'b01; RegSrc = Funct[0] ? 2'b00 : 2'b10; end
        2'b10:   begin ImmSrc = 2'b10; RegSrc = 2'b01; end
        default: begin ImmSrc = 2'b00; RegSrc = 2'b00; end
      endcase
    end
    case (state_q)
      StFetch:   begin irw = 1'b1; pcw = 1'b1; sa = 2'b01; sb = 2'b10; rs = 2'b10; end
      StDecode:  begin sa = 2'b01; sb = 2'b10; rs = 2'b10; ill = condex & illegal_dec; end
      StExecR:   alu_sel = alu_q;
      StExecI:   begin sb = 2'b01; alu_sel = alu_q; end
      StMulWait: alu_sel = 4'b0010;
      StAluWb:   begin regw = 1'b1; pcw = (Rd == PC_REG); end
      StMemAdr:  sb = 2'b01;
      StMemRd:   adr = 1'b1;
      StMemWb:   begin rs = 2'b01; regw = 1'b1; pcw = (Rd == PC_REG); end
      StMemWr:   begin adr = 1'b1; memw = 1'b1; end
      StBranch:  begin sa = 2'b10; sb = 2'b01; rs = 2'b10; pcw = 1'b1; end
      default:   ;
    endcase
  end

  // Write enables are suppressed in the reset cycle itself.
  assign PCWrite    = pcw & ~reset;
  assign IRWrite    = irw & ~reset;
  assign RegW       = regw & ~reset;
  assign MemW       = memw & ~reset;
  assign Illegal    = ill & ~reset;
  assign AdrSrc     = adr;
  assign ResultSrc  = rs;
  assign ALUSrcA    = sa;
  assign ALUSrcB    = sb;
  assign ALUControl = ALUCTL_W'(alu_sel);
  assign Flags      = flags_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: per-instruction expected output traces from a behavioural model,
// compared every cycle, plus directed literal checks.
module tb_multicycle_controller;

  localparam int unsigned L = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd, Cond, ALUFlags;
  logic       PCWrite, AdrSrc, MemW, IRWrite, RegW, Illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc;
  logic [3:0] ALUControl, Flags;

  multicycle_controller #(.ALUCTL_W(4), .MUL_LATENCY(L), .PC_REG(4'd15)) dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd), .Cond(Cond),
    .ALUFlags(ALUFlags), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemW(MemW),
    .IRWrite(IRWrite), .RegW(RegW), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl),
    .Flags(Flags), .Illegal(Illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pcw, adr, memw, irw, regw, ill;
    logic [1:0] rs, sa, sb, imm, regsrc;
    logic [3:0] alu, flags;
  } exp_t;

  exp_t       q[$];
  exp_t       cur;
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  logic [7:0] regw_tr, pcw_tr, memw_tr, ill_tr;
  logic [3:0] mf = 4'b0000;
  logic [3:0] af[16];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      cur = q.pop_front();
      chk("PCWrite", 16'(PCWrite), 16'(cur.pcw));
      chk("AdrSrc", 16'(AdrSrc), 16'(cur.adr));
      chk("MemW", 16'(MemW), 16'(cur.memw));
      chk("IRWrite", 16'(IRWrite), 16'(cur.irw));
      chk("RegW", 16'(RegW), 16'(cur.regw));
      chk("Illegal", 16'(Illegal), 16'(cur.ill));
      chk("ResultSrc", 16'(ResultSrc), 16'(cur.rs));
      chk("ALUSrcA", 16'(ALUSrcA), 16'(cur.sa));
      chk("ALUSrcB", 16'(ALUSrcB), 16'(cur.sb));
      chk("ImmSrc", 16'(ImmSrc), 16'(cur.imm));
      chk("RegSrc", 16'(RegSrc), 16'(cur.regsrc));
      chk("ALUControl", 16'(ALUControl), 16'(cur.alu));
      chk("Flags", 16'(Flags), 16'(cur.flags));
      if (cyc < 8) begin
        regw_tr[cyc] = RegW;
        pcw_tr[cyc]  = PCWrite;
        memw_tr[cyc] = MemW;
        ill_tr[cyc]  = Illegal;
      end
    end
  end

  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    {n, z, cf, v} = f;
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cf;
      4'd3:  return !cf;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cf && !z;
      4'd9:  return !cf || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  function automatic int alu_code(input logic [3:0] cmd);
    case (cmd)
      4'b0100: return 0;
      4'b0010: return 1;
      4'b0000: return 2;
      4'b1100: return 3;
      4'b1101: return 6;
      4'b1010: return 1;
      default: return -1;
    endcase
  endfunction

  function automatic exp_t blank(input logic [1:0] imm, input logic [1:0] rsrc);
    exp_t e;
    e        = '0;
    e.imm    = imm;
    e.regsrc = rsrc;
    e.flags  = mf;
    return e;
  endfunction

  // Expected cycle-by-cycle behaviour of one instruction, from the architectural rules.
  task automatic build(input logic [1:0] op, input logic [5:0] funct, input logic [3:0] rd,
                       input logic [3:0] cond);
    exp_t       e;
    logic [1:0] imm, rsrc;
    int         code, ai;
    logic       ce, ill, mul, cmp, cvop;
    case (op)
      2'd1:    begin imm = 2'b01; rsrc = funct[0] ? 2'b00 : 2'b10; end
      2'd2:    begin imm = 2'b10; rsrc = 2'b01; end
      default: begin imm = 2'b00; rsrc = 2'b00; end
    endcase
    ce   = cond_ok(cond, mf);
    code = alu_code(funct[4:1]);
    ill  = ce && (op == 2'd3 || (op == 2'd0 && code < 0));
    e = blank(2'b00, 2'b00);
    e.irw = 1; e.pcw = 1; e.sa = 2'b01; e.sb = 2'b10; e.rs = 2'b10;
    q.push_back(e);
    e = blank(imm, rsrc);
    e.sa = 2'b01; e.sb = 2'b10; e.rs = 2'b10; e.ill = ill;
    q.push_back(e);
    if (!ce || ill) return;
    case (op)
      2'd0: begin
        mul  = (funct[4:1] == 4'b0000);
        cmp  = (funct[4:1] == 4'b1010);
        cvop = (funct[4:1] == 4'b0100) || (funct[4:1] == 4'b0010) || cmp;
        e = blank(imm, rsrc);
        e.sb  = funct[5] ? 2'b01 : 2'b00;
        e.alu = code[3:0];
        q.push_back(e);
        ai = 2;
        if (mul && L > 1) begin
          for (int k = 1; k < int'(L); k++) begin
            e = blank(imm, rsrc);
            e.alu = 4'b0010;
            q.push_back(e);
          end
          ai = 1 + int'(L);
        end
        if (funct[0]) begin
          mf[3:2] = af[ai][3:2];
          if (cvop) mf[1:0] = af[ai][1:0];
        end
        if (!cmp) begin
          e = blank(imm, rsrc);
          e.regw = 1; e.pcw = (rd == 4'd15);
          q.push_back(e);
        end
      end
      2'd1: begin
        e = blank(imm, rsrc);
        e.sb = 2'b01;
        q.push_back(e);
        if (funct[0]) begin
          e = blank(imm, rsrc); e.adr = 1; q.push_back(e);
          e = blank(imm, rsrc); e.rs = 2'b01; e.regw = 1; e.pcw = (rd == 4'd15);
          q.push_back(e);
        end else begin
          e = blank(imm, rsrc); e.adr = 1; e.memw = 1; q.push_back(e);
        end
      end
      default: begin
        e = blank(imm, rsrc);
        e.sa = 2'b10; e.sb = 2'b01; e.rs = 2'b10; e.pcw = 1;
        q.push_back(e);
      end
    endcase
  endtask

  // Entered and left at #1 after the edge that starts a FETCH cycle.
  task automatic run_instr(input logic [1:0] op, input logic [5:0] funct,
                           input logic [3:0] rd, input logic [3:0] cond,
                           input bit fix, input logic [3:0] fv);
    int n;
    for (int i = 0; i < 16; i++) af[i] = fix ? fv : 4'($urandom_range(0, 15));
    build(op, funct, rd, cond);
    n = q.size();
    regw_tr = '0; pcw_tr = '0; memw_tr = '0; ill_tr = '0;
    Op = op; Funct = funct; Rd = rd; Cond = cond;
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      cyc = i;
      ALUFlags = af[i];
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; Op = 2'd0; Funct = 6'd0; Rd = 4'd0; Cond = 4'he; ALUFlags = 4'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_irwrite", 16'(IRWrite), 16'd0);
    chk("reset_pcwrite", 16'(PCWrite), 16'd0);
    chk("reset_flags", 16'(Flags), 16'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    run_instr(2'd0, 6'b001000, 4'd3, 4'he, 1'b0, 4'd0);
    chk("add_regw_trace", 16'(regw_tr), 16'h08);
    chk("add_pcw_trace", 16'(pcw_tr), 16'h01);
    run_instr(2'd0, 6'b000101, 4'd2, 4'he, 1'b1, 4'b0110);
    chk("subs_flags", 16'(Flags), 16'b0110);
    run_instr(2'd0, 6'b011001, 4'd2, 4'he, 1'b1, 4'b1000);
    chk("orrs_flags", 16'(Flags), 16'b1010);
    run_instr(2'd1, 6'b011001, 4'd5, 4'he, 1'b0, 4'd0);
    chk("ldr_regw_trace", 16'(regw_tr), 16'h10);
    run_instr(2'd1, 6'b011000, 4'd5, 4'he, 1'b0, 4'd0);
    chk("str_memw_trace", 16'(memw_tr), 16'h08);
    run_instr(2'd0, 6'b000000, 4'd4, 4'he, 1'b0, 4'd0);
    chk("mul_regw_trace", 16'(regw_tr), 16'h20);
    run_instr(2'd0, 6'b001000, 4'd3, 4'h0, 1'b0, 4'd0);
    chk("eq_fail_regw", 16'(regw_tr), 16'h00);
    chk("eq_fail_pcw", 16'(pcw_tr), 16'h01);
    run_instr(2'd2, 6'b000000, 4'd0, 4'he, 1'b0, 4'd0);
    chk("branch_pcw_trace", 16'(pcw_tr), 16'h05);
    run_instr(2'd0, 6'b001000, 4'd15, 4'he, 1'b0, 4'd0);
    chk("add_pc_pcw_trace", 16'(pcw_tr), 16'h09);
    run_instr(2'd3, 6'b001000, 4'd1, 4'hf, 1'b0, 4'd0);
    chk("illegal_trace", 16'(ill_tr), 16'h02);

    // Reset while the store is in its memory-write cycle.
    Op = 2'd1; Funct = 6'b011000; Rd = 4'd1; Cond = 4'he;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    @(negedge clk);
    chk("reset_in_memwr_memw", 16'(MemW), 16'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("after_reset_irwrite", 16'(IRWrite), 16'd1);
    chk("after_reset_flags", 16'(Flags), 16'd0);
    mf = 4'b0000;

    for (int t = 0; t < 300; t++) begin
      run_instr(2'($urandom_range(0, 3)), 6'($urandom_range(0, 63)),
                4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b0, 4'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
